// File: rtl/aes_input_rand_ctrl_if.sv
// Handshake bundle between the host, the RNG word stream, the random-input
// controller and the AES core datapath.
interface aes_input_rand_ctrl_if #(
  parameter int RAND_W = 1024,
  parameter int RNG_W  = 32
);
  logic              start_i;
  logic              abort_i;
  logic              busy_o;
  logic [RNG_W-1:0]  rng_data_i;
  logic              rng_valid_i;
  logic              rng_ready_o;
  logic [RAND_W-1:0] rand_o;
  logic              core_load_o;
  logic              core_done_i;
  logic              done_o;

  modport slave (
    input  start_i, abort_i, rng_data_i, rng_valid_i, core_done_i,
    output busy_o, rng_ready_o, rand_o, core_load_o, done_o
  );

  modport master (
    output start_i, abort_i, rng_data_i, rng_valid_i, core_done_i,
    input  busy_o, rng_ready_o, rand_o, core_load_o, done_o
  );
endinterface

// File: rtl/aes_input_rand_ctrl.sv
// Collects a fresh RNG-filled random vector for each AES block, pulses the core
// load with it, zeroizes it afterwards and waits for the core to finish.
module aes_input_rand_ctrl #(
  parameter int RAND_W = 1024,
  parameter int RNG_W  = 32
) (
  input logic                clk_i,
  input logic                rst_i,
  aes_input_rand_ctrl_if.slave bus
);

  localparam int NWORDS = (RAND_W + RNG_W - 1) / RNG_W;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {IDLE, FILL, LOAD, RUN} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [RAND_W-1:0] rand_q;
  logic              busy_q;
  logic              ready_q;
  logic              load_q;
  logic              done_q;

  // Word k lands at bit k*RNG_W; the RAND_W-wide cast drops the excess of the last word.
  logic [RAND_W-1:0] word_val;
  logic [RAND_W-1:0] word_mask;
  logic              last_word;

  assign word_val  = RAND_W'(bus.rng_data_i) << (cnt * RNG_W);
  assign word_mask = RAND_W'({RNG_W{1'b1}}) << (cnt * RNG_W);
  assign last_word = (cnt == CNT_W'(NWORDS - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      rand_q  <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      load_q <= 1'b0;
      done_q <= 1'b0;
      if (bus.abort_i) begin
        state   <= IDLE;
        cnt     <= '0;
        rand_q  <= '0;
        busy_q  <= 1'b0;
        ready_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start_i) begin
              state   <= FILL;
              cnt     <= '0;
              busy_q  <= 1'b1;
              ready_q <= 1'b1;
            end
          end
          FILL: begin
            if (bus.rng_valid_i && ready_q) begin
              rand_q <= (rand_q & ~word_mask) | word_val;
              if (last_word) begin
                state   <= LOAD;
                cnt     <= '0;
                ready_q <= 1'b0;
                load_q  <= 1'b1;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          LOAD: begin
            // The core has sampled the vector this cycle; never let it linger.
            rand_q <= '0;
            cnt    <= '0;
            state  <= RUN;
          end
          RUN: begin
            if (bus.core_done_i) begin
              state  <= IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy_o      = busy_q;
  assign bus.rng_ready_o = ready_q;
  assign bus.rand_o      = rand_q;
  assign bus.core_load_o = load_q;
  assign bus.done_o      = done_q;

endmodule

// File: tb/tb_aes_input_rand_ctrl.sv
// Directed and randomized checks of aes_input_rand_ctrl with a 72-bit random
// vector built from three 32-bit RNG words.
module tb_aes_input_rand_ctrl;

  localparam int RAND_W = 72;
  localparam int RNG_W  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  aes_input_rand_ctrl_if #(.RAND_W(RAND_W), .RNG_W(RNG_W)) bus ();

  aes_input_rand_ctrl #(.RAND_W(RAND_W), .RNG_W(RNG_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // Expected vector: word0 in bits 31:0, word1 in 63:32, low byte of word2 in 71:64.
  function automatic logic [71:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
    logic [71:0] r;
    r = 72'(a) + (72'(b) * 72'h1_0000_0000) + (72'(c % 256) * (72'd1 << 64));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] flags();
    return {bus.busy_o, bus.rng_ready_o, bus.core_load_o, bus.done_o};
  endfunction

  // Runs one block from IDLE (or the done cycle) and ends on the done_o sample.
  task automatic do_block(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                          input int s0, input int s1, input int s2, input bit noise,
                          input int run_wait, input logic [71:0] exp_rand, input string tag);
    logic [31:0] w[3];
    int s[3];
    int bad_load, bad_ready, bad_done, bad_run;
    w[0] = w0; w[1] = w1; w[2] = w2;
    s[0] = s0; s[1] = s1; s[2] = s2;
    bad_load = 0; bad_ready = 0; bad_done = 0; bad_run = 0;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    chk({tag, "_fill_entry"}, flags(), 4'b1100);
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < s[k]; j++) begin
        bus.rng_valid_i = 1'b0;
        bus.rng_data_i  = $urandom;
        if (noise) begin
          bus.start_i     = 1'b1;
          bus.core_done_i = 1'b1;
        end
        tick();
        bus.start_i     = 1'b0;
        bus.core_done_i = 1'b0;
        if (!bus.rng_ready_o || !bus.busy_o) bad_ready++;
        if (bus.core_load_o) bad_load++;
        if (bus.done_o) bad_done++;
      end
      bus.rng_valid_i = 1'b1;
      bus.rng_data_i  = w[k];
      if (noise) bus.start_i = 1'b1;
      tick();
      bus.rng_valid_i = 1'b0;
      bus.start_i     = 1'b0;
      bus.rng_data_i  = $urandom;
      if (k < 2) begin
        if (!bus.rng_ready_o) bad_ready++;
        if (bus.core_load_o) bad_load++;
        if (bus.done_o) bad_done++;
      end
    end
    chk({tag, "_early_load"}, bad_load, 0);
    chk({tag, "_fill_ready"}, bad_ready, 0);
    chk({tag, "_fill_done"}, bad_done, 0);
    chk({tag, "_load_flags"}, flags(), 4'b1010);
    chk({tag, "_load_rand"}, bus.rand_o, exp_rand);
    if (noise) begin
      bus.start_i     = 1'b1;
      bus.rng_valid_i = 1'b1;
    end
    tick();
    chk({tag, "_run_flags"}, flags(), 4'b1000);
    chk({tag, "_run_rand"}, bus.rand_o, 72'd0);
    for (int j = 0; j < run_wait; j++) begin
      tick();
      if (flags() !== 4'b1000 || bus.rand_o !== 72'd0) bad_run++;
    end
    chk({tag, "_run_hold"}, bad_run, 0);
    bus.start_i     = 1'b0;
    bus.rng_valid_i = 1'b0;
    bus.core_done_i = 1'b1;
    tick();
    bus.core_done_i = 1'b0;
    chk({tag, "_done"}, flags(), 4'b0001);
  endtask

  initial begin
    logic [31:0] a, b, c;
    int ns[3];
    bus.start_i     = 1'b0;
    bus.abort_i     = 1'b0;
    bus.rng_data_i  = '0;
    bus.rng_valid_i = 1'b0;
    bus.core_done_i = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", flags(), 4'b0000);
    chk("reset_rand", bus.rand_o, 72'd0);
    rst = 1'b0;
    tick();
    chk("idle_after_reset", flags(), 4'b0000);

    // Basic block, RNG valid every cycle.
    do_block(32'h11111111, 32'h22222222, 32'hAABBCCDD, 0, 0, 0, 1'b0, 2,
             72'hDD_22222222_11111111, "basic");
    tick();
    chk("basic_done_pulse", flags(), 4'b0000);

    // Five stall cycles before the second word.
    do_block(32'h11111111, 32'h22222222, 32'hAABBCCDD, 0, 5, 0, 1'b0, 1,
             72'hDD_22222222_11111111, "stall");
    tick();

    // start_i during FILL/RUN and core_done_i during FILL are ignored.
    do_block(32'hCAFEF00D, 32'h0BADBEEF, 32'h12345678, 1, 2, 1, 1'b1, 3,
             model(32'hCAFEF00D, 32'h0BADBEEF, 32'h12345678), "noise");
    tick();
    chk("noise_single_done", flags(), 4'b0000);

    // Abort after two words, then start+abort together, then a clean block.
    bus.start_i = 1'b1;
    tick();
    bus.start_i     = 1'b0;
    bus.rng_valid_i = 1'b1;
    bus.rng_data_i  = 32'h1;
    tick();
    bus.rng_data_i = 32'h2;
    tick();
    bus.rng_valid_i = 1'b0;
    chk("abort_partial_rand", bus.rand_o, model(32'h1, 32'h2, 32'h0));
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    chk("abort_flags", flags(), 4'b0000);
    chk("abort_rand", bus.rand_o, 72'd0);
    bus.start_i = 1'b1;
    bus.abort_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    chk("abort_start_ignored", flags(), 4'b0000);
    do_block(32'h1, 32'h2, 32'h3, 0, 0, 0, 1'b0, 0, 72'h03_00000002_00000001, "post_abort");
    tick();

    // Abort in LOAD: pulse already out, block abandoned, no done.
    bus.start_i = 1'b1;
    tick();
    bus.start_i     = 1'b0;
    bus.rng_valid_i = 1'b1;
    repeat (3) begin
      bus.rng_data_i = $urandom;
      tick();
    end
    bus.rng_valid_i = 1'b0;
    chk("abort_load_pulse", flags(), 4'b1010);
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i     = 1'b0;
    chk("abort_load_flags", flags(), 4'b0000);
    chk("abort_load_rand", bus.rand_o, 72'd0);
    bus.core_done_i = 1'b1;
    tick();
    bus.core_done_i = 1'b0;
    chk("abort_load_no_done", flags(), 4'b0000);

    // Back-to-back: start_i in the done_o cycle.
    do_block(32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFF77, 0, 0, 0, 1'b0, 1,
             model(32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFF77), "chain_a");
    do_block(32'h01234567, 32'h89ABCDEF, 32'h000000E1, 0, 1, 0, 1'b0, 1,
             model(32'h01234567, 32'h89ABCDEF, 32'h000000E1), "chain_b");
    tick();

    // Asynchronous reset in the middle of FILL.
    bus.start_i = 1'b1;
    tick();
    bus.start_i     = 1'b0;
    bus.rng_valid_i = 1'b1;
    bus.rng_data_i  = 32'hDEADBEEF;
    tick();
    bus.rng_valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_flags", flags(), 4'b0000);
    chk("async_rst_rand", bus.rand_o, 72'd0);
    #2 rst = 1'b0;
    tick();
    chk("after_rst_idle", flags(), 4'b0000);

    // Randomized blocks against the model.
    for (int r = 0; r < 10; r++) begin
      a = $urandom;
      b = $urandom;
      c = $urandom;
      for (int k = 0; k < 3; k++) ns[k] = $urandom_range(0, 3);
      do_block(a, b, c, ns[0], ns[1], ns[2], 1'($urandom_range(0, 1)),
               $urandom_range(0, 4), model(a, b, c), $sformatf("rnd%0d", r));
      if ($urandom_range(0, 1) == 1) begin
        tick();
        chk($sformatf("rnd%0d_idle", r), flags(), 4'b0000);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_input_rand_ctrl.md
Name: aes_input_rand_ctrl

Overview:
- Sequences the masked-input conversion stage of the AES-128 encryption core: collects a fresh random vector from an external RNG word stream, presents it as the stage's random bus, pulses the core load, and waits for completion.
- Guarantees every block gets a fully fresh random vector, never reused, and zeroized after the load cycle.
- Sits between the host start/done interface, the RNG, and the core datapath.

Parameters:
RAND_W, 1024, total random bits consumed per block (width of rand_o); must be >= 1
RNG_W, 32, width of one RNG word; must be >= 1
NWORDS (localparam), ceil(RAND_W/RNG_W), RNG words fetched per block

Ports:
clk_i  in  1  clock; all logic rising-edge
rst_i  in  1  reset; asynchronous, active-high
start_i  in  1  request one block; accepted only when busy_o=0
abort_i  in  1  synchronous abort; effective in any state
busy_o  out  1  high in every state except IDLE
rng_data_i  in  RNG_W  RNG word
rng_valid_i  in  1  RNG word valid
rng_ready_o  out  1  controller accepts RNG word; high only in FILL
rand_o  out  RAND_W  random vector to the masked-input stage
core_load_o  out  1  one-cycle pulse: core samples converted state/key/noise
core_done_i  in  1  core finished block
done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset values: busy_o=0, rng_ready_o=0, rand_o=0, core_load_o=0, done_o=0, word counter=0, FSM=IDLE.
- FSM states: IDLE, FILL, LOAD, RUN. All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE:
  - start_i=1 moves to FILL and clears the counter.
  - start_i while busy_o=1 is ignored, with no queuing.
- FILL:
  - rng_ready_o=1. On rng_valid_i & rng_ready_o, word k (k=counter) is written to rand_o[k*RNG_W +: RNG_W], and the counter increments.
  - On the final word (k=NWORDS-1), only the low RAND_W-(NWORDS-1)*RNG_W bits are kept; the upper bits are discarded.
  - The handshake on the final word moves to LOAD on the next edge.
  - Cycles with rng_valid_i=0 stall indefinitely; there is no timeout.
- LOAD:
  - core_load_o=1 for exactly one cycle, with rand_o fully populated that cycle.
  - Next edge: rand_o cleared to 0, counter cleared, move to RUN.
- RUN:
  - rand_o stays 0.
  - core_done_i=1 moves to IDLE, and done_o=1 for exactly the cycle after (registered).
- Inputs outside their states:
  - core_done_i outside RUN is ignored.
  - rng_valid_i outside FILL is ignored, since rng_ready_o=0.
- Latency:
  - Accepting start to core_load_o is NWORDS+1 cycles minimum, with RNG valid every cycle (start edge, NWORDS fill edges, then LOAD).
  - core_done_i to done_o is 1 cycle.
- abort_i:
  - Takes priority over all other inputs. Next edge: FSM=IDLE, rand_o=0, counter=0, no done_o.
  - If asserted in LOAD, core_load_o is still high that cycle (already decoded) but the block is abandoned.
  - start_i in the same cycle as abort_i is ignored.
- Simultaneous start_i and done_o: done_o is high in IDLE. start_i sampled that cycle is accepted (back-to-back blocks).
- Reset mid-operation: immediate return to reset values, with partial random data destroyed.

Test Plan:
- RAND_W=72, RNG_W=32, RNG valid every cycle with words 0x11111111, 0x22222222, 0xAABBCCDD -> core_load_o high the 4th cycle after the start edge; rand_o=0xDD_22222222_11111111 during load; rand_o=0 the cycle after.
- Same config, rng_valid_i low for 5 cycles between words 1 and 2 -> rng_ready_o stays high; load delayed by exactly 5 cycles; same rand_o value.
- start_i pulsed during FILL and RUN -> ignored; only one core_load_o; one done_o after core_done_i.
- abort_i after 2 words, then a new start with words 0x1, 0x2, 0x3 -> IDLE the next cycle with rand_o=0; the new block's rand_o=0x03_00000002_00000001 (no stale data).
- done_o cycle coinciding with start_i=1 -> new FILL begins immediately; core_done_i pulsed while in FILL -> no done_o.
- rst_i asserted asynchronously mid-FILL -> all outputs 0 before the next clock edge; FSM in IDLE after release.
